// File: rtl/counter_stimulus_sequencer_if.sv
// Host/counter bus of the counter stimulus sequencer: script programming, run control,
// counter controls and checker status.
interface counter_stimulus_sequencer_if #(
  parameter int unsigned N       = 32,
  parameter int unsigned STEPS   = 16,
  parameter int unsigned DWELL_W = 8
);
  localparam int unsigned AW = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic               prog_we;
  logic [AW-1:0]      prog_addr;
  logic [3:0]         prog_ctrl;
  logic [N-1:0]       prog_value;
  logic [DWELL_W-1:0] prog_dwell;
  logic               start;
  logic [N-1:0]       counterN;
  logic               cnt_reset;
  logic               cnt_load;
  logic               cnt_enable;
  logic               cnt_dec;
  logic [N-1:0]       cnt_load_value;
  logic               busy;
  logic               done;
  logic               error;
  logic [AW-1:0]      err_step;
  logic [N-1:0]       expected;

  modport master (
    output prog_we, prog_addr, prog_ctrl, prog_value, prog_dwell, start, counterN,
    input  cnt_reset, cnt_load, cnt_enable, cnt_dec, cnt_load_value,
    input  busy, done, error, err_step, expected
  );

  modport slave (
    input  prog_we, prog_addr, prog_ctrl, prog_value, prog_dwell, start, counterN,
    output cnt_reset, cnt_load, cnt_enable, cnt_dec, cnt_load_value,
    output busy, done, error, err_step, expected
  );
endinterface

// File: rtl/counter_stimulus_sequencer.sv
// Replays a programmed script of counter control steps; with SEQ_CHECK_EN defined it also
// runs a reference model of the counter and latches the first mismatch.
module counter_stimulus_sequencer #(
  parameter int unsigned N       = 32,
  parameter int unsigned STEPS   = 16,
  parameter int unsigned DWELL_W = 8
) (
  input logic                    clock,
  input logic                    reset,
  counter_stimulus_sequencer_if.slave bus
);
  localparam int unsigned AW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned CW = 4;
  localparam logic [AW-1:0] LAST_STEP = AW'(STEPS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Control word bit positions: {rst, load, en, dec}
  localparam int unsigned C_RST  = 3;
  localparam int unsigned C_LOAD = 2;
  localparam int unsigned C_EN   = 1;
  localparam int unsigned C_DEC  = 0;

  logic [CW-1:0]      scr_ctrl  [STEPS];
  logic [N-1:0]       scr_value [STEPS];
  logic [DWELL_W-1:0] scr_dwell [STEPS];

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CW-1:0]      ctrl_q, ctrl_d;
  logic [N-1:0]       value_q, value_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               run_start_c;

  // Script storage survives reset; writes are locked out while a run is in progress.
  always_ff @(posedge clock) begin
    if (bus.prog_we && !busy_q) begin
      scr_ctrl[bus.prog_addr]  <= bus.prog_ctrl;
      scr_value[bus.prog_addr] <= bus.prog_value;
      scr_dwell[bus.prog_addr] <= bus.prog_dwell;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dwell_d     = dwell_q;
    ctrl_d      = ctrl_q;
    value_d     = value_q;
    busy_d      = busy_q;
    done_d      = done_q;
    run_start_c = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        // busy stays up for the first DONE cycle so the last step's effect is still compared
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (bus.start) begin
          state_d     = S_FETCH;
          idx_d       = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          run_start_c = 1'b1;
        end
      end
      S_FETCH: begin
        if (scr_dwell[idx_q] == '0) begin
          state_d = S_DONE;
        end else begin
          dwell_d = scr_dwell[idx_q];
          ctrl_d  = scr_ctrl[idx_q];
          value_d = scr_value[idx_q];
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        if (dwell_q == DWELL_W'(1)) begin
          ctrl_d  = '0;
          value_d = '0;
          idx_d   = idx_q + AW'(1);
          state_d = (idx_q == LAST_STEP) ? S_DONE : S_FETCH;
        end else begin
          dwell_d = dwell_q - DWELL_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      ctrl_q  <= '0;
      value_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      ctrl_q  <= ctrl_d;
      value_q <= value_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.cnt_reset      = ctrl_q[C_RST];
  assign bus.cnt_load       = ctrl_q[C_LOAD];
  assign bus.cnt_enable     = ctrl_q[C_EN];
  assign bus.cnt_dec        = ctrl_q[C_DEC];
  assign bus.cnt_load_value = value_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

`ifdef SEQ_CHECK_EN
  logic [N-1:0]  model_q;
  logic          valid_q;
  logic          error_q;
  logic [AW-1:0] err_step_q;
  logic          mismatch_c;

  // The model tracks the counter through the same registered controls, so counterN
  // is compared against model_q one cycle after the controls that produced it.
  assign mismatch_c = busy_q && valid_q && (bus.counterN != model_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      model_q    <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      err_step_q <= '0;
    end else begin
      if (ctrl_q[C_RST])
        model_q <= '0;
      else if (ctrl_q[C_LOAD])
        model_q <= value_q;
      else if (ctrl_q[C_EN])
        model_q <= ctrl_q[C_DEC] ? (model_q - N'(1)) : (model_q + N'(1));

      if (run_start_c) begin
        valid_q    <= 1'b0;
        error_q    <= 1'b0;
        err_step_q <= '0;
      end else begin
        if (ctrl_q[C_RST] || ctrl_q[C_LOAD])
          valid_q <= 1'b1;
        if (mismatch_c && !error_q) begin
          error_q    <= 1'b1;
          err_step_q <= idx_q;
        end
      end
    end
  end

  assign bus.error    = error_q;
  assign bus.err_step = err_step_q;
  assign bus.expected = model_q;
`else
  logic unused_ok;
  assign unused_ok    = ^{bus.counterN, run_start_c};
  assign bus.error    = 1'b0;
  assign bus.err_step = '0;
  assign bus.expected = '0;
`endif
endmodule

// File: tb/tb_counter_stimulus_sequencer.sv
// Randomized self-checking bench for counter_stimulus_sequencer: predicts the control
// waveform from the script and models the counter arithmetically (SEQ_CHECK_EN aware).
module tb_counter_stimulus_sequencer;
  localparam int unsigned N       = 32;
  localparam int unsigned STEPS   = 16;
  localparam int unsigned DWELL_W = 8;
  localparam int unsigned AW      = 4;

  typedef struct {
    logic [3:0]    ctrl;
    logic [N-1:0]  val;
    bit            busy;
    bit            done;
    logic [AW-1:0] step;
  } obs_t;

  logic clock = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  string phase = "init";

  logic [N-1:0] ctr = 32'h1234_5678;
  bit           force5 = 1'b0;

  logic [3:0]         s_ctrl  [STEPS];
  logic [N-1:0]       s_val   [STEPS];
  logic [DWELL_W-1:0] s_dwell [STEPS];

  logic [N-1:0]  m = '0;
  bit            mv = 1'b0;
  bit            err_e = 1'b0;
  logic [AW-1:0] err_step_e = '0;
  obs_t          q[$];

  always #5 clock = ~clock;

  counter_stimulus_sequencer_if #(.N(N), .STEPS(STEPS), .DWELL_W(DWELL_W)) bus ();

  counter_stimulus_sequencer #(.N(N), .STEPS(STEPS), .DWELL_W(DWELL_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Counter under test: a correct up/down/load counter, optionally overridden with 5
  assign bus.counterN = force5 ? N'(5) : ctr;

  always @(posedge clock) begin
    if (bus.cnt_reset)       ctr <= '0;
    else if (bus.cnt_load)   ctr <= bus.cnt_load_value;
    else if (bus.cnt_enable) ctr <= bus.cnt_dec ? ctr - 1 : ctr + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] next_val(input logic [N-1:0] v, input logic [3:0] c,
                                            input logic [N-1:0] ld);
    if (c[3]) return '0;
    if (c[2]) return ld;
    if (c[1]) return c[0] ? v - 1 : v + 1;
    return v;
  endfunction

  task automatic prog(input int a, input logic [3:0] c, input logic [N-1:0] v,
                      input logic [DWELL_W-1:0] d);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = AW'(a);
    bus.prog_ctrl  = c;
    bus.prog_value = v;
    bus.prog_dwell = d;
    @(posedge clock);
    #1;
    bus.prog_we = 1'b0;
    s_ctrl[a]   = c;
    s_val[a]    = v;
    s_dwell[a]  = d;
  endtask

  function automatic void push(input logic [3:0] c, input logic [N-1:0] v, input bit b,
                               input bit dn, input int s);
    obs_t o;
    o.ctrl = c; o.val = v; o.busy = b; o.done = dn; o.step = AW'(s);
    q.push_back(o);
  endfunction

  // Per-cycle expected outputs after the start edge: FETCH, dwell cycles per step, ...
  function automatic void build_schedule();
    q.delete();
    push(4'd0, '0, 1'b1, 1'b0, 0);
    for (int i = 0; i < STEPS; i++) begin
      if (s_dwell[i] == '0) begin
        push(4'd0, '0, 1'b1, 1'b0, i);
        push(4'd0, '0, 1'b0, 1'b1, i);
        break;
      end
      for (int k = 0; k < int'(s_dwell[i]); k++) push(s_ctrl[i], s_val[i], 1'b1, 1'b0, i);
      if (i == STEPS - 1) begin
        push(4'd0, '0, 1'b1, 1'b0, 0);
        push(4'd0, '0, 1'b0, 1'b1, 0);
      end else begin
        push(4'd0, '0, 1'b1, 1'b0, i + 1);
      end
    end
  endfunction

  task automatic check_outputs(input obs_t o);
    check("ctrl", {bus.cnt_reset, bus.cnt_load, bus.cnt_enable, bus.cnt_dec}, o.ctrl);
    check("load_value", bus.cnt_load_value, o.val);
    check("busy", bus.busy, o.busy);
    check("done", bus.done, o.done);
`ifdef SEQ_CHECK_EN
    check("expected", bus.expected, m);
    check("error", bus.error, err_e);
`else
    check("expected", bus.expected, 0);
    check("error", bus.error, 0);
`endif
  endtask

  task automatic run(input bit fault, input int noise_at, input bit abort);
    obs_t p;
    logic [N-1:0] cn_prev;
    int abort_at;
    abort_at = -1;
    build_schedule();
    if (abort) begin
      for (int t = 0; t < q.size(); t++)
        if (q[t].step == AW'(1) && q[t].ctrl != 4'd0) begin abort_at = t; break; end
      check("abort_point_found", abort_at >= 0, 1);
    end
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    mv = 1'b0; err_e = 1'b0; err_step_e = '0;
    cn_prev = ctr;
    for (int t = 0; t < q.size(); t++) begin
      if (t > 0) begin
        @(posedge clock);
        #1;
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
        p = q[t-1];
        if (p.busy && mv && cn_prev != m && !err_e) begin
          err_e = 1'b1;
          err_step_e = p.step;
        end
        m = next_val(m, p.ctrl, p.val);
        if (p.ctrl[3] || p.ctrl[2]) mv = 1'b1;
      end
      check_outputs(q[t]);
      if (abort && t == abort_at) begin
        #2 reset = 1'b1;
        #1;
        m = '0; mv = 1'b0; err_e = 1'b0; err_step_e = '0; force5 = 1'b0;
        check("rst_ctrl", {bus.cnt_reset, bus.cnt_load, bus.cnt_enable, bus.cnt_dec}, 0);
        check("rst_value", bus.cnt_load_value, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_err_step", bus.err_step, 0);
        check("rst_expected", bus.expected, 0);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        return;
      end
      if (fault && q[t].step == AW'(2) && q[t].ctrl != 4'd0) force5 = 1'b1;
      cn_prev = force5 ? N'(5) : ctr;
      if (t == noise_at && q[t].busy && t < q.size() - 1) begin
        bus.start      = 1'b1;
        bus.prog_we    = 1'b1;
        bus.prog_addr  = AW'($urandom);
        bus.prog_ctrl  = 4'($urandom);
        bus.prog_value = $urandom;
        bus.prog_dwell = DWELL_W'($urandom);
      end
    end
    force5 = 1'b0;
`ifdef SEQ_CHECK_EN
    check("err_step", bus.err_step, err_step_e);
`else
    check("err_step", bus.err_step, 0);
`endif
  endtask

  function automatic logic [N-1:0] pick_value();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return N'(1);
      default: return $urandom;
    endcase
  endfunction

  task automatic prog_script_b();
    prog(0, 4'b0100, 32'hFFFF_FFFF, 1);
    prog(1, 4'b0010, 0, 1);
    prog(2, 4'b0100, 0, 1);
    prog(3, 4'b0011, 0, 1);
    prog(4, 4'b0000, 0, 0);
  endtask

  task automatic prog_script_a();
    prog(0, 4'b0100, 32, 1);
    prog(1, 4'b0010, 0, 3);
    prog(2, 4'b0011, 0, 2);
    prog(3, 4'b0000, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_ctrl  = '0;
    bus.prog_value = '0;
    bus.prog_dwell = '0;
    bus.start      = 1'b0;
    #12;
    phase = "reset";
    check_outputs('{ctrl: 4'd0, val: '0, busy: 1'b0, done: 1'b0, step: '0});
    check("err_step", bus.err_step, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    phase = "rst_dwell2";
    prog(0, 4'b1000, 0, 2);
    prog(1, 4'b0000, 0, 0);
    run(1'b0, -1, 1'b0);

    phase = "load_en_dec";
    prog_script_a();
    run(1'b0, -1, 1'b0);
`ifdef SEQ_CHECK_EN
    check("final_33", bus.expected, 33);
`endif

    phase = "wrap_values";
    prog_script_b();
    run(1'b0, 5, 1'b0);

    phase = "mismatch";
    run(1'b1, -1, 1'b0);
`ifdef SEQ_CHECK_EN
    check("mismatch_error", bus.error, 1);
    check("mismatch_step", bus.err_step, 2);
`endif

    phase = "abort";
    prog_script_a();
    run(1'b0, -1, 1'b1);
    phase = "rerun";
    run(1'b0, -1, 1'b0);

    phase = "full16";
    for (int i = 0; i < STEPS; i++)
      prog(i, (i == 0) ? 4'b0100 : 4'($urandom), pick_value(), DWELL_W'($urandom_range(1, 3)));
    run(1'b0, int'($urandom_range(0, 30)), 1'b0);

    for (int r = 0; r < 8; r++) begin
      int len;
      phase = $sformatf("random%0d", r);
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++)
        prog(i, (i == 0) ? (4'($urandom) | 4'b0100) : 4'($urandom), pick_value(),
             DWELL_W'($urandom_range(1, 4)));
      prog(len, 4'($urandom), pick_value(), 0);
      run(r[0], int'($urandom_range(0, 20)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
